mrr_loopback_push_arbiter: RTL and testbench
============================================

// Module: mrr_loopback_push_arbiter
// PURPOSE
//   Round-robin arbiter sharing the per-node loopback queue's single push port between NUM_SOURCES
//   producers (host AXI regs, uplink decode chains). Captures the granted source's chip ID/message,
//   runs the queue's push_request/push_ack 4-phase handshake, then acks the source (also 4-phase).
//   Flags stalled pushes (queue full / slow search) and counts completed pushes.
// PARAMETERS
//   NUM_SOURCES     4     number of push requesters (>=2)
//   CHIP_ID_LEN     8     destination chip ID width
//   MSG_LEN         64    loopback message width
//   STALL_CYCLES    1024  PUSH-state cycles before stall_timeout asserts (<2^16)
// PORTS
//   clk             in   1                      system clock
//   rst_n           in   1                      reset, asynchronous, active-low
//   src_req         in   NUM_SOURCES            per-source push request, held until src_ack
//   src_chip_id     in   NUM_SOURCES*CHIP_ID_LEN per-source chip ID, slice i = [(i+1)*CHIP_ID_LEN-1-:CHIP_ID_LEN]
//   src_message     in   NUM_SOURCES*MSG_LEN    per-source message, same slicing
//   src_ack         out  NUM_SOURCES            one-hot ack, held until that src_req drops
//   q_push_request  out  1                      to queue push_request
//   q_push_chip_id  out  CHIP_ID_LEN            to queue push_chip_id (latched copy)
//   q_push_message  out  MSG_LEN                to queue push_message (latched copy)
//   q_push_ack      in   1                      from queue push_ack
//   grant_idx       out  $clog2(NUM_SOURCES)    source currently/last served
//   stall_timeout   out  1                      current push waited >= STALL_CYCLES
//   push_count      out  16                     completed pushes, saturating at 16'hFFFF
// BEHAVIOUR
//   - All outputs registered. rst_n low (async): state=IDLE, rr_ptr=0, src_ack=0, q_push_request=0,
//     q_push_chip_id=0, q_push_message=0, grant_idx=0, stall_timeout=0, push_count=0, stall_cnt=0.
//   - Arbitration: in IDLE, scan from rr_ptr upward, wrapping at NUM_SOURCES-1 -> 0; first asserted
//     src_req wins. Winner index, chip ID and message latched on the grant edge.
//   - FSM:
//     IDLE: any src_req -> PUSH; q_push_request<=1 on same edge (1 cycle req->push latency).
//     PUSH: hold q_push_request=1 and latched payload; stall_cnt+1 per cycle (saturating).
//           q_push_ack=1 sampled -> ACK_SRC: q_push_request<=0, src_ack[grant]<=1,
//           push_count+1 (saturating), stall_cnt<=0, stall_timeout<=0.
//     ACK_SRC: keep src_ack[grant]=1 until src_req[grant]==0 AND q_push_ack==0 sampled ->
//           IDLE: src_ack<=0, rr_ptr<=(grant==NUM_SOURCES-1)?0:grant+1.
//   - stall_timeout<=1 when stall_cnt reaches STALL_CYCLES-1 in PUSH; remains 1 until push acked.
//     Stall never aborts the push (queue keeps searching; dropping request could corrupt queue).
//   - Requests from non-granted sources are ignored until IDLE; they stay pending (src_req held).
//   - Source dropping src_req while in PUSH (protocol violation): push still completes with
//     latched payload; ACK_SRC exits as soon as q_push_ack==0; src_ack pulses >=1 cycle.
//   - Payload changes on src_* after grant have no effect on q_push_*.
//   - Minimum back-to-back service: IDLE->PUSH->...->ACK_SRC->IDLE; IDLE lasts exactly 1 cycle.
//   - Same reset domain as the queue; reset mid-push returns both to idle, in-flight message lost.
// TESTING
//   1 Single: src_req=4'b0010, chip 8'h2A, msg 64'hDEAD_BEEF -> next edge q_push_request=1 with same
//     payload, grant_idx=1; after q_push_ack, src_ack=4'b0010 until src_req drops; push_count=1.
//   2 Fairness: src_req=4'b1111 held, each src re-requests immediately -> grant order 0,1,2,3,0,...
//     no source served twice while another pending.
//   3 Wrap: rr_ptr=3, src_req=4'b1001 -> grant 3 then 0; rr_ptr returns to 1 after second push.
//   4 Stall: STALL_CYCLES=8, q_push_ack held 0 for 20 cycles -> stall_timeout=1 from 8th PUSH
//     cycle, q_push_request stays 1; ack arrives -> stall_timeout=0, push_count increments.
//   5 Payload change: alter src_message[0] 2 cycles after grant -> q_push_message unchanged.
//   6 Async reset during PUSH (rst_n low mid-cycle) -> q_push_request, src_ack, counters 0
//     immediately, without a clock edge; fresh request after release served from source 0.

Source files
------------

// File: rtl/mrr_loopback_push_arbiter.sv
// Round-robin arbiter that shares the loopback queue's single push port between several producers.
// It latches the winner's payload, runs the 4-phase queue push, then 4-phase acks the source.
module mrr_loopback_push_arbiter #(
  parameter int NUM_SOURCES  = 4,
  parameter int CHIP_ID_LEN  = 8,
  parameter int MSG_LEN      = 64,
  parameter int STALL_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_SOURCES-1:0]             src_req,
  input  logic [NUM_SOURCES*CHIP_ID_LEN-1:0] src_chip_id,
  input  logic [NUM_SOURCES*MSG_LEN-1:0]     src_message,
  output logic [NUM_SOURCES-1:0]             src_ack,
  output logic                               q_push_request,
  output logic [CHIP_ID_LEN-1:0]             q_push_chip_id,
  output logic [MSG_LEN-1:0]                 q_push_message,
  input  logic                               q_push_ack,
  output logic [$clog2(NUM_SOURCES)-1:0]     grant_idx,
  output logic                               stall_timeout,
  output logic [15:0]                        push_count
);

  localparam int IDX_W = $clog2(NUM_SOURCES);
  localparam logic [IDX_W:0] SRC_CNT = (IDX_W+1)'(NUM_SOURCES);
  localparam logic [IDX_W-1:0] LAST_SRC = IDX_W'(NUM_SOURCES - 1);
  localparam logic [16:0] STALL_LAST = 17'(STALL_CYCLES - 1);
  localparam logic STALL_AT_GRANT = (STALL_CYCLES <= 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PUSH    = 2'd1;
  localparam logic [1:0] ST_ACK_SRC = 2'd2;

  logic [1:0]             state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [15:0]            stall_cnt;
  logic [CHIP_ID_LEN-1:0] chip_arr [NUM_SOURCES];
  logic [MSG_LEN-1:0]     msg_arr  [NUM_SOURCES];
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic [IDX_W:0]         cand;

  generate
    for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_unpack
      assign chip_arr[gi] = src_chip_id[(gi+1)*CHIP_ID_LEN-1 -: CHIP_ID_LEN];
      assign msg_arr[gi]  = src_message[(gi+1)*MSG_LEN-1 -: MSG_LEN];
    end
  endgenerate

  // Scan offsets high-to-low so the request closest to rr_ptr overrides the others.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = rr_ptr;
    cand       = '0;
    for (int off = NUM_SOURCES - 1; off >= 0; off--) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(off);
      if (cand >= SRC_CNT) cand = cand - SRC_CNT;
      if (src_req[cand[IDX_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      rr_ptr         <= '0;
      src_ack        <= '0;
      q_push_request <= 1'b0;
      q_push_chip_id <= '0;
      q_push_message <= '0;
      grant_idx      <= '0;
      stall_timeout  <= 1'b0;
      push_count     <= '0;
      stall_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state          <= ST_PUSH;
            grant_idx      <= pick_idx;
            q_push_request <= 1'b1;
            q_push_chip_id <= chip_arr[pick_idx];
            q_push_message <= msg_arr[pick_idx];
            stall_cnt      <= '0;
            stall_timeout  <= STALL_AT_GRANT;
          end
        end
        ST_PUSH: begin
          if (q_push_ack) begin
            state          <= ST_ACK_SRC;
            q_push_request <= 1'b0;
            src_ack        <= NUM_SOURCES'(1) << grant_idx;
            stall_cnt      <= '0;
            stall_timeout  <= 1'b0;
            if (push_count != 16'hFFFF) push_count <= push_count + 16'd1;
          end else begin
            // Stall is only reported; the push is never withdrawn while the queue searches.
            if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
            if (({1'b0, stall_cnt} + 17'd1) >= STALL_LAST) stall_timeout <= 1'b1;
          end
        end
        ST_ACK_SRC: begin
          if (!src_req[grant_idx] && !q_push_ack) begin
            state   <= ST_IDLE;
            src_ack <= '0;
            rr_ptr  <= (grant_idx == LAST_SRC) ? '0 : grant_idx + IDX_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mrr_loopback_push_arbiter.sv
// Bench for mrr_loopback_push_arbiter: vector table, hand-written corner sequences, and a
// randomized run checked against a transaction-level round-robin model.
module tb_mrr_loopback_push_arbiter;
  localparam int N  = 4;
  localparam int CW = 8;
  localparam int MW = 64;
  localparam int SC = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    src_req = '0;
  logic [N*CW-1:0] src_chip_id = '0;
  logic [N*MW-1:0] src_message = '0;
  logic [N-1:0]    src_ack;
  logic            q_push_request;
  logic [CW-1:0]   q_push_chip_id;
  logic [MW-1:0]   q_push_message;
  logic            q_push_ack = 1'b0;
  logic [1:0]      grant_idx;
  logic            stall_timeout;
  logic [15:0]     push_count;

  int tests = 0;
  int fails = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  mrr_loopback_push_arbiter #(
    .NUM_SOURCES(N), .CHIP_ID_LEN(CW), .MSG_LEN(MW), .STALL_CYCLES(SC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_chip_id(src_chip_id),
    .src_message(src_message), .src_ack(src_ack), .q_push_request(q_push_request),
    .q_push_chip_id(q_push_chip_id), .q_push_message(q_push_message), .q_push_ack(q_push_ack),
    .grant_idx(grant_idx), .stall_timeout(stall_timeout), .push_count(push_count)
  );

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  chip_base;
    logic [63:0] msg_base;
    int          exp_grant;
    logic [7:0]  exp_chip;
    logic [63:0] exp_msg;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load_payload(input logic [7:0] cb, input logic [63:0] mb);
    for (int s = 0; s < N; s++) begin
      src_chip_id[s*CW +: CW] = cb + 8'(s);
      src_message[s*MW +: MW] = mb + 64'(s);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int ptr);
    for (int off = 0; off < N; off++) begin
      int i;
      i = (ptr + off) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // One complete transaction: grant, push, queue ack, source ack, release.
  task automatic do_push(input string name, input logic [3:0] req, input logic [7:0] cb,
                         input logic [63:0] mb, input int eg, input logic [7:0] ec,
                         input logic [63:0] em);
    logic [3:0] onehot;
    onehot = 4'(1) << eg;
    load_payload(cb, mb);
    src_req = req;
    @(posedge clk); #1;
    check({name, " q_push_request"}, 64'(q_push_request), 64'(1));
    check({name, " grant_idx"}, 64'(grant_idx), 64'(eg));
    check({name, " chip_id"}, 64'(q_push_chip_id), 64'(ec));
    check({name, " message"}, q_push_message, em);
    repeat (2) @(posedge clk);
    #1;
    check({name, " hold request"}, 64'(q_push_request), 64'(1));
    check({name, " no early ack"}, 64'(src_ack), 64'(0));
    q_push_ack = 1'b1;
    if (exp_count < 16'hFFFF) exp_count++;
    @(posedge clk); #1;
    check({name, " request drop"}, 64'(q_push_request), 64'(0));
    check({name, " src_ack"}, 64'(src_ack), 64'(onehot));
    check({name, " push_count"}, 64'(push_count), 64'(exp_count));
    q_push_ack = 1'b0;
    @(posedge clk); #1;
    check({name, " src_ack held"}, 64'(src_ack), 64'(onehot));
    src_req = src_req & ~onehot;
    @(posedge clk); #1;
    check({name, " src_ack release"}, 64'(src_ack), 64'(0));
    $display("[TB] %s: src %0d pushed chip=%0h msg=%0h count=%0d", name, eg, ec, em, exp_count);
  endtask

  logic [3:0]      app_req;
  logic [N*CW-1:0] app_chip;
  logic [N*MW-1:0] app_msg;
  int              cool[N];
  int              delay;
  bit              m_busy;
  bit              ack_seen;
  int              m_ptr;
  int              m_win;

  initial begin
    vecs[0] = '{4'b0010, 8'h29, 64'hDEAD_BEEE, 1, 8'h2A, 64'hDEAD_BEEF};
    vecs[1] = '{4'b1111, 8'h10, 64'h1000, 2, 8'h12, 64'h1002};
    vecs[2] = '{4'b1001, 8'h20, 64'h2000, 3, 8'h23, 64'h2003};
    vecs[3] = '{4'b1001, 8'h30, 64'h3000, 0, 8'h30, 64'h3000};
    vecs[4] = '{4'b1001, 8'h40, 64'h4000, 3, 8'h43, 64'h4003};
    vecs[5] = '{4'b0110, 8'h50, 64'h5000, 1, 8'h51, 64'h5001};
    vecs[6] = '{4'b0001, 8'h60, 64'h6000, 0, 8'h60, 64'h6000};
    vecs[7] = '{4'b1000, 8'h70, 64'h7000, 3, 8'h73, 64'h7003};

    repeat (3) @(posedge clk);
    #1;
    check("reset q_push_request", 64'(q_push_request), 64'(0));
    check("reset src_ack", 64'(src_ack), 64'(0));
    check("reset grant_idx", 64'(grant_idx), 64'(0));
    check("reset stall_timeout", 64'(stall_timeout), 64'(0));
    check("reset push_count", 64'(push_count), 64'(0));
    check("reset chip_id", 64'(q_push_chip_id), 64'(0));
    check("reset message", q_push_message, 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++)
      do_push($sformatf("vec%0d", v), vecs[v].req, vecs[v].chip_base, vecs[v].msg_base,
              vecs[v].exp_grant, vecs[v].exp_chip, vecs[v].exp_msg);

    // All sources requesting continuously: service rotates strictly.
    for (int i = 0; i < 6; i++)
      do_push($sformatf("fair%0d", i), 4'b1111, 8'h80 + 8'(i * 4), 64'h8000 + 64'(i * 16),
              i % N, 8'h80 + 8'(i * 4) + 8'(i % N), 64'h8000 + 64'(i * 16) + 64'(i % N));

    // Stall: queue withholds ack for 20 PUSH cycles.
    load_payload(8'hA0, 64'hA000);
    src_req = 4'b0100;
    @(posedge clk); #1;
    check("stall grant_idx", 64'(grant_idx), 64'(2));
    for (int k = 1; k <= 20; k++) begin
      check($sformatf("stall timeout c%0d", k), 64'(stall_timeout), 64'(k >= SC));
      check($sformatf("stall request c%0d", k), 64'(q_push_request), 64'(1));
      if (k < 20) begin
        @(posedge clk); #1;
      end
    end
    q_push_ack = 1'b1;
    exp_count++;
    @(posedge clk); #1;
    check("stall timeout clear", 64'(stall_timeout), 64'(0));
    check("stall push_count", 64'(push_count), 64'(exp_count));
    check("stall src_ack", 64'(src_ack), 64'(4'b0100));
    src_req = '0;
    q_push_ack = 1'b0;
    @(posedge clk); #1;
    check("stall release", 64'(src_ack), 64'(0));
    $display("[TB] stall: src 2 pushed after 20 cycles count=%0d", exp_count);

    // Payload altered after grant must not reach the queue.
    load_payload(8'hC0, 64'hC0C0_0000);
    src_req = 4'b0001;
    @(posedge clk); #1;
    check("payload grant_idx", 64'(grant_idx), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    src_message = ~src_message;
    src_chip_id = ~src_chip_id;
    @(posedge clk); #1;
    check("payload message held", q_push_message, 64'hC0C0_0000);
    check("payload chip held", 64'(q_push_chip_id), 64'(8'hC0));
    q_push_ack = 1'b1;
    exp_count++;
    @(posedge clk); #1;
    src_req = '0;
    q_push_ack = 1'b0;
    @(posedge clk); #1;
    check("payload release", 64'(src_ack), 64'(0));
    $display("[TB] payload: src 0 pushed chip=c0 count=%0d", exp_count);

    // Asynchronous reset in the middle of a push.
    load_payload(8'hE0, 64'hE000);
    src_req = 4'b1000;
    @(posedge clk); #1;
    check("areset grant_idx", 64'(grant_idx), 64'(3));
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("areset q_push_request", 64'(q_push_request), 64'(0));
    check("areset src_ack", 64'(src_ack), 64'(0));
    check("areset push_count", 64'(push_count), 64'(0));
    check("areset grant_idx zero", 64'(grant_idx), 64'(0));
    check("areset message", q_push_message, 64'(0));
    exp_count = 0;
    src_req = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("[TB] areset: in-flight push dropped");
    do_push("post_reset", 4'b1111, 8'hF0, 64'hF000, 0, 8'hF0, 64'hF000);

    // Randomized traffic against a transaction-level round-robin model.
    m_ptr = 1;
    m_busy = 0;
    ack_seen = 0;
    m_win = 0;
    delay = 0;
    for (int s = 0; s < N; s++) cool[s] = 0;
    for (int c = 0; c < 3000; c++) begin
      app_req = src_req;
      app_chip = src_chip_id;
      app_msg = src_message;
      @(posedge clk); #1;
      if (!m_busy) begin
        check("rnd grant on request", 64'(q_push_request), 64'(app_req != 0));
        if (q_push_request) begin
          m_win = rr_pick(app_req, m_ptr);
          if (m_win >= 0) begin
            check("rnd grant_idx", 64'(grant_idx), 64'(m_win));
            check("rnd chip_id", 64'(q_push_chip_id), 64'(app_chip[m_win*CW +: CW]));
            check("rnd message", q_push_message, app_msg[m_win*MW +: MW]);
          end
          m_busy = 1;
          ack_seen = 0;
        end
      end else if (src_ack != 0 && !ack_seen) begin
        ack_seen = 1;
        if (exp_count < 16'hFFFF) exp_count++;
        check("rnd src_ack", 64'(src_ack), 64'(4'(1) << m_win));
        check("rnd push_count", 64'(push_count), 64'(exp_count));
        $display("[TB] rnd: src %0d pushed count=%0d", m_win, exp_count);
      end else if (src_ack == 0 && ack_seen) begin
        m_ptr = (m_win + 1) % N;
        m_busy = 0;
      end
      check("rnd stall_timeout", 64'(stall_timeout), 64'(0));

      if (q_push_request && !q_push_ack) begin
        if (delay == 0) q_push_ack = 1'b1;
        else delay--;
      end else if (!q_push_request && q_push_ack) begin
        q_push_ack = 1'b0;
        delay = int'($urandom_range(0, 3));
      end

      for (int s = 0; s < N; s++) begin
        if (src_req[s]) begin
          if (src_ack[s]) begin
            src_req[s] = 1'b0;
            cool[s] = int'($urandom_range(0, 3));
          end
        end else if (!src_ack[s]) begin
          if (cool[s] > 0) cool[s]--;
          else if ($urandom_range(0, 1) == 1) begin
            src_chip_id[s*CW +: CW] = 8'($urandom);
            src_message[s*MW +: MW] = {$urandom, $urandom};
            src_req[s] = 1'b1;
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
